// File: rtl/leds_axil_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master port to the leds register bank
// between two single-word requesters; out-of-range commands are answered locally with SLVERR.
module leds_axil_arbiter #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                NUM_REGS  = 4
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [1:0]          req_we,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [63:0]         req_wdata,
    input  logic [7:0]          req_wstrb,
    output logic [1:0]          rsp_valid,
    output logic [31:0]         rsp_rdata,
    output logic [1:0]          rsp_resp,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [2:0]          m_axi_awprot,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [31:0]         m_axi_wdata,
    output logic [3:0]          m_axi_wstrb,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    output logic [ADDR_W-1:0]   m_axi_araddr,
    output logic [2:0]          m_axi_arprot,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,
    input  logic [31:0]         m_axi_rdata,
    input  logic [1:0]          m_axi_rresp,
    input  logic                m_axi_rvalid,
    output logic                m_axi_rready
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WR   = 3'd1;
    localparam logic [2:0] S_WB   = 3'd2;
    localparam logic [2:0] S_RA   = 3'd3;
    localparam logic [2:0] S_RD   = 3'd4;
    localparam logic [2:0] S_RSP  = 3'd5;

    // One extra bit so BASE_ADDR + span cannot wrap at the top of the address space
    localparam logic [ADDR_W:0] BASE_EXT  = {1'b0, BASE_ADDR};
    localparam logic [ADDR_W:0] LIMIT_EXT = BASE_EXT + (ADDR_W+1)'(4 * NUM_REGS);

    logic [2:0]        state_reg;
    logic              gnt_reg;
    logic              last_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [31:0]       wdata_reg;
    logic [3:0]        wstrb_reg;
    logic              awvalid_reg;
    logic              wvalid_reg;
    logic              arvalid_reg;
    logic [31:0]       rdata_reg;
    logic [1:0]        resp_reg;

    logic              gnt;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic [3:0]        sel_wstrb;
    logic              in_range;
    logic              aw_ok;
    logic              w_ok;

    always_comb begin
        gnt = 1'b0;
        case (req_valid)
            2'b10:   gnt = 1'b1;
            2'b11:   gnt = ~last_reg;
            default: gnt = 1'b0;
        endcase
    end

    assign sel_we    = gnt ? req_we[1]                     : req_we[0];
    assign sel_addr  = gnt ? req_addr[ADDR_W +: ADDR_W]    : req_addr[0 +: ADDR_W];
    assign sel_wdata = gnt ? req_wdata[63:32]              : req_wdata[31:0];
    assign sel_wstrb = gnt ? req_wstrb[7:4]                : req_wstrb[3:0];
    assign in_range  = ({1'b0, sel_addr} >= BASE_EXT) && ({1'b0, sel_addr} < LIMIT_EXT);

    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        assign req_ready[gi] = (state_reg == S_IDLE) && req_valid[gi] && (gnt == 1'(gi));
        assign rsp_valid[gi] = (state_reg == S_RSP) && (gnt_reg == 1'(gi));
    end

    // A channel counts as done once its valid has dropped or it handshakes this cycle
    assign aw_ok = !awvalid_reg || m_axi_awready;
    assign w_ok  = !wvalid_reg  || m_axi_wready;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_reg   <= S_IDLE;
            gnt_reg     <= 1'b0;
            last_reg    <= 1'b1;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
            awvalid_reg <= 1'b0;
            wvalid_reg  <= 1'b0;
            arvalid_reg <= 1'b0;
            rdata_reg   <= '0;
            resp_reg    <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (|req_ready) begin
                        gnt_reg   <= gnt;
                        last_reg  <= gnt;
                        addr_reg  <= {sel_addr[ADDR_W-1:2], 2'b00};
                        wdata_reg <= sel_wdata;
                        wstrb_reg <= sel_wstrb;
                        if (!in_range) begin
                            rdata_reg <= '0;
                            resp_reg  <= 2'b10;
                            state_reg <= S_RSP;
                        end else if (sel_we) begin
                            awvalid_reg <= 1'b1;
                            wvalid_reg  <= 1'b1;
                            state_reg   <= S_WR;
                        end else begin
                            arvalid_reg <= 1'b1;
                            state_reg   <= S_RA;
                        end
                    end
                end
                S_WR: begin
                    if (m_axi_awready) awvalid_reg <= 1'b0;
                    if (m_axi_wready)  wvalid_reg  <= 1'b0;
                    if (aw_ok && w_ok) state_reg   <= S_WB;
                end
                S_WB: begin
                    if (m_axi_bvalid) begin
                        resp_reg  <= m_axi_bresp;
                        rdata_reg <= '0;
                        state_reg <= S_RSP;
                    end
                end
                S_RA: begin
                    if (m_axi_arready) begin
                        arvalid_reg <= 1'b0;
                        state_reg   <= S_RD;
                    end
                end
                S_RD: begin
                    if (m_axi_rvalid) begin
                        rdata_reg <= m_axi_rdata;
                        resp_reg  <= m_axi_rresp;
                        state_reg <= S_RSP;
                    end
                end
                S_RSP:   state_reg <= S_IDLE;
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign rsp_rdata     = rdata_reg;
    assign rsp_resp      = resp_reg;
    assign m_axi_awaddr  = addr_reg;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awvalid_reg;
    assign m_axi_wdata   = wdata_reg;
    assign m_axi_wstrb   = wstrb_reg;
    assign m_axi_wvalid  = wvalid_reg;
    assign m_axi_bready  = (state_reg == S_WB);
    assign m_axi_araddr  = addr_reg;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = arvalid_reg;
    assign m_axi_rready  = (state_reg == S_RD);

endmodule

// File: tb/tb_leds_axil_arbiter.sv
// Bench for leds_axil_arbiter: behavioural leds slave, two requester tasks and a
// response scoreboard fed with expected responses in grant order.
module tb_leds_axil_arbiter;

    localparam int ADDR_W = 32;

    logic tb_ACLK = 1'b0;
    logic tb_ARESET = 1'b1;
    always #5 tb_ACLK = ~tb_ACLK;

    logic [1:0]          req_valid, req_ready, req_we;
    logic [2*ADDR_W-1:0] req_addr;
    logic [63:0]         req_wdata;
    logic [7:0]          req_wstrb;
    logic [1:0]          rsp_valid, rsp_resp;
    logic [31:0]         rsp_rdata;
    logic [ADDR_W-1:0]   m_axi_awaddr, m_axi_araddr;
    logic [2:0]          m_axi_awprot, m_axi_arprot;
    logic                m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [31:0]         m_axi_wdata, m_axi_rdata;
    logic [3:0]          m_axi_wstrb;
    logic [1:0]          m_axi_bresp, m_axi_rresp;
    logic                m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic                m_axi_rvalid, m_axi_rready;

    leds_axil_arbiter #(.ADDR_W(ADDR_W), .BASE_ADDR(32'h0), .NUM_REGS(4)) dut (
        .ACLK(tb_ACLK), .ARESET(tb_ARESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    int n_vec = 0;
    int n_miss = 0;
    int cyc = 0;
    int rsp_cyc = 0;
    always @(posedge tb_ACLK) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- leds slave model ----------------
    logic [31:0]       s_regs [0:3];
    logic              s_aw_got = 1'b0, s_w_got = 1'b0;
    logic [ADDR_W-1:0] s_aw_addr = '0;
    logic [31:0]       s_w_data = '0;
    logic [3:0]        s_w_strb = '0;
    int                s_wcnt = 0;
    int                w_delay = 0;
    logic              b_hold = 1'b0;
    int                aw_hs_cnt = 0, w_hs_cnt = 0, ar_hs_cnt = 0, b_hs_cyc = 0;

    assign m_axi_awready = 1'b1;
    assign m_axi_arready = 1'b1;

    wire               aw_hs = m_axi_awvalid & m_axi_awready;
    wire               w_hs  = m_axi_wvalid & m_axi_wready;
    wire               ar_hs = m_axi_arvalid & m_axi_arready;
    wire [ADDR_W-1:0]  s_wr_addr = aw_hs ? m_axi_awaddr : s_aw_addr;
    wire [31:0]        s_wr_data = w_hs ? m_axi_wdata : s_w_data;
    wire [3:0]         s_wr_strb = w_hs ? m_axi_wstrb : s_w_strb;
    wire               s_aw_any  = s_aw_got | aw_hs;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    always @(posedge tb_ACLK) begin
        if (tb_ARESET) begin
            for (int k = 0; k < 4; k++) s_regs[k] <= '0;
            s_aw_got <= 1'b0; s_w_got <= 1'b0; s_wcnt <= 0;
            m_axi_bvalid <= 1'b0; m_axi_bresp <= '0;
            m_axi_rvalid <= 1'b0; m_axi_rresp <= '0; m_axi_rdata <= '0;
            m_axi_wready <= (w_delay == 0);
        end else begin
            if (aw_hs) begin
                s_aw_got <= 1'b1; s_aw_addr <= m_axi_awaddr; aw_hs_cnt <= aw_hs_cnt + 1;
            end
            if (w_hs) begin
                s_w_got <= 1'b1; s_w_data <= m_axi_wdata; s_w_strb <= m_axi_wstrb;
                w_hs_cnt <= w_hs_cnt + 1;
            end
            if (s_aw_any && (s_w_got || w_hs)) begin
                s_regs[s_wr_addr[3:2]] <= merge(s_regs[s_wr_addr[3:2]], s_wr_data, s_wr_strb);
                s_aw_got <= 1'b0; s_w_got <= 1'b0;
                m_axi_bvalid <= !b_hold; m_axi_bresp <= 2'b00;
            end
            if (m_axi_bvalid && m_axi_bready) begin
                m_axi_bvalid <= 1'b0; b_hs_cyc <= cyc;
            end
            if (w_delay == 0) m_axi_wready <= 1'b1;
            else if (w_hs) begin
                m_axi_wready <= 1'b0; s_wcnt <= 0;
            end else if (!s_aw_any) begin
                m_axi_wready <= 1'b0; s_wcnt <= 0;
            end else if (!m_axi_wready) begin
                if (s_wcnt >= w_delay - 1) m_axi_wready <= 1'b1;
                else s_wcnt <= s_wcnt + 1;
            end
            if (ar_hs) begin
                m_axi_rvalid <= 1'b1; m_axi_rdata <= s_regs[m_axi_araddr[3:2]];
                m_axi_rresp <= 2'b00; ar_hs_cnt <= ar_hs_cnt + 1;
            end
            if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [1:0]  onehot;
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    task automatic expect_rsp(input int id, input logic [1:0] resp, input logic [31:0] data);
        exp_t e;
        e.onehot = (id == 0) ? 2'b01 : 2'b10;
        e.resp   = resp;
        e.data   = data;
        sb.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge tb_ACLK);
            if (!tb_ARESET && rsp_valid != 2'b00) begin
                rsp_cyc = cyc;
                if (sb.size() == 0) check_val("unexpected_rsp", {62'd0, rsp_valid}, 64'd0);
                else begin
                    e = sb.pop_front();
                    $display("rsp valid=%b resp=%0d rdata=0x%08h", rsp_valid, rsp_resp, rsp_rdata);
                    check_val("rsp_valid", {62'd0, rsp_valid}, {62'd0, e.onehot});
                    check_val("rsp_resp", {62'd0, rsp_resp}, {62'd0, e.resp});
                    check_val("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e.data});
                end
            end
        end
    end

    // ---------------- requester driver ----------------
    task automatic issue(input int i, input logic we, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] strb, output int acc_cyc);
        logic ok;
        ok = 1'b0;
        acc_cyc = 0;
        req_we[i] = we;
        req_addr[i*32 +: 32] = addr;
        req_wdata[i*32 +: 32] = data;
        req_wstrb[i*4 +: 4] = strb;
        req_valid[i] = 1'b1;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge tb_ACLK);
            if (req_ready[i]) begin
                ok = 1'b1;
                acc_cyc = cyc;
            end
        end
        if (!ok) check_val($sformatf("accept_timeout_r%0d", i), {63'd0, ok}, 64'd1);
        @(posedge tb_ACLK); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int k = 0; k < 300 && sb.size() != 0; k++) @(negedge tb_ACLK);
        if (sb.size() != 0) check_val(tag, 64'(sb.size()), 64'd0);
        @(posedge tb_ACLK); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int acc, a0, a1, aw0, w0, ar0;
        int t0 [0:2];
        int t1 [0:2];
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        tb_ARESET = 1'b1;
        repeat (3) @(posedge tb_ACLK);
        #1;
        check_val("rst_handshakes", {57'd0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                  m_axi_bready, m_axi_rready, rsp_valid}, 64'd0);
        check_val("rst_req_ready", {62'd0, req_ready}, 64'd0);
        check_val("rst_rsp_data", {30'd0, rsp_resp, rsp_rdata}, 64'd0);
        check_val("rst_addr", {m_axi_awaddr, m_axi_araddr}, 64'd0);
        check_val("rst_wdata", {28'd0, m_axi_wstrb, m_axi_wdata}, 64'd0);
        check_val("rst_prot", {58'd0, m_axi_awprot, m_axi_arprot}, 64'd0);
        tb_ARESET = 1'b0;
        @(posedge tb_ACLK); #1;

        // 1: write then read back on requester 0
        expect_rsp(0, 2'b00, 32'h0);
        issue(0, 1'b1, 32'h0, 32'h0101FFFF, 4'hF, acc);
        wait_drain("t1_wr_drain");
        check_val("t1_wr_latency", 64'(rsp_cyc - acc), 64'd3);
        expect_rsp(0, 2'b00, 32'h0101FFFF);
        issue(0, 1'b0, 32'h0, 32'h0, 4'h0, acc);
        wait_drain("t1_rd_drain");
        check_val("t1_rd_latency", 64'(rsp_cyc - acc), 64'd3);

        // 2: simultaneous requests after reset, requester 0 wins the first tie
        tb_ARESET = 1'b1;
        @(posedge tb_ACLK); #1;
        tb_ARESET = 1'b0;
        expect_rsp(0, 2'b00, 32'h0);
        expect_rsp(1, 2'b00, 32'h0);
        fork
            issue(0, 1'b1, 32'h4, 32'hABCD0001, 4'hF, a0);
            issue(1, 1'b1, 32'h8, 32'hDEAD0011, 4'hF, a1);
        join
        wait_drain("t2_wr_drain");
        check_val("t2_grant_order", 64'(a1 - a0), 64'd4);
        expect_rsp(0, 2'b00, 32'hABCD0001);
        issue(0, 1'b0, 32'h4, 32'h0, 4'h0, acc);
        expect_rsp(1, 2'b00, 32'hDEAD0011);
        issue(1, 1'b0, 32'h8, 32'h0, 4'h0, acc);
        wait_drain("t2_rd_drain");

        // 3: both held valid, grants alternate 0,1,0,1,0,1 every 4 cycles
        for (int j = 0; j < 3; j++) begin
            expect_rsp(0, 2'b00, 32'hABCD0001);
            expect_rsp(1, 2'b00, 32'hDEAD0011);
        end
        fork
            begin
                for (int j = 0; j < 3; j++) issue(0, 1'b0, 32'h4, 32'h0, 4'h0, t0[j]);
            end
            begin
                for (int j = 0; j < 3; j++) issue(1, 1'b0, 32'h8, 32'h0, 4'h0, t1[j]);
            end
        join
        wait_drain("t3_drain");
        for (int j = 0; j < 3; j++) begin
            check_val($sformatf("t3_gap_0to1_%0d", j), 64'(t1[j] - t0[j]), 64'd4);
            if (j < 2) check_val($sformatf("t3_gap_1to0_%0d", j), 64'(t0[j+1] - t1[j]), 64'd4);
        end

        // 4: wready lags awready by 3 cycles; partial strobe write
        w_delay = 3;
        @(posedge tb_ACLK); #1;
        aw0 = aw_hs_cnt; w0 = w_hs_cnt;
        expect_rsp(0, 2'b00, 32'h0);
        issue(0, 1'b1, 32'hC, 32'h12345678, 4'b0011, acc);
        wait_drain("t4_wr_drain");
        check_val("t4_aw_count", 64'(aw_hs_cnt - aw0), 64'd1);
        check_val("t4_w_count", 64'(w_hs_cnt - w0), 64'd1);
        check_val("t4_rsp_after_b", {63'd0, rsp_cyc > b_hs_cyc}, 64'd1);
        check_val("t4_latency", 64'(rsp_cyc - acc), 64'd6);
        w_delay = 0;
        @(posedge tb_ACLK); #1;
        expect_rsp(0, 2'b00, 32'h00005678);
        issue(0, 1'b0, 32'hC, 32'h0, 4'h0, acc);
        wait_drain("t4_rd_drain");

        // 5: out-of-range reads rejected locally; low address bits ignored in range
        ar0 = ar_hs_cnt;
        expect_rsp(1, 2'b10, 32'h0);
        issue(1, 1'b0, 32'h10, 32'h0, 4'h0, acc);
        wait_drain("t5_oor_drain");
        check_val("t5_no_ar", 64'(ar_hs_cnt - ar0), 64'd0);
        check_val("t5_latency_le2", {63'd0, (rsp_cyc - acc) <= 2}, 64'd1);
        expect_rsp(1, 2'b10, 32'h0);
        issue(1, 1'b0, 32'hFFFFFFFC, 32'h0, 4'h0, acc);
        wait_drain("t5_top_drain");
        check_val("t5_no_ar_top", 64'(ar_hs_cnt - ar0), 64'd0);
        expect_rsp(1, 2'b00, 32'h00005678);
        issue(1, 1'b0, 32'hF, 32'h0, 4'h0, acc);
        wait_drain("t5_low_bits_drain");

        // 6: reset while waiting for B, then a clean write/read
        b_hold = 1'b1;
        issue(0, 1'b1, 32'h4, 32'h11112222, 4'hF, acc);
        for (int k = 0; k < 50 && !m_axi_bready; k++) @(negedge tb_ACLK);
        check_val("t6_in_wb", {63'd0, m_axi_bready}, 64'd1);
        tb_ARESET = 1'b1;
        @(posedge tb_ACLK); #1;
        check_val("t6_rst_handshakes", {57'd0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                  m_axi_bready, m_axi_rready, rsp_valid}, 64'd0);
        check_val("t6_rst_addr", {m_axi_awaddr, m_axi_araddr}, 64'd0);
        check_val("t6_rst_rsp", {30'd0, rsp_resp, rsp_rdata}, 64'd0);
        tb_ARESET = 1'b0;
        b_hold = 1'b0;
        repeat (3) @(posedge tb_ACLK);
        #1;
        expect_rsp(0, 2'b00, 32'h0);
        issue(0, 1'b1, 32'hC, 32'hBEEF0011, 4'hF, acc);
        wait_drain("t6_wr_drain");
        expect_rsp(0, 2'b00, 32'hBEEF0011);
        issue(0, 1'b0, 32'hC, 32'h0, 4'h0, acc);
        wait_drain("t6_rd_drain");

        repeat (2) @(posedge tb_ACLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
